rr_mux: RTL and testbench
=========================

# rr_mux

Parametrised, registered N-channel multiplexer with per-channel valid/ready handshake and a runtime-selectable arbitration mode. It extends the 2:1 gate-level mux to CHANNELS inputs of WIDTH bits, adds a one-entry output register, and either forwards a software-selected channel (fixed mode) or shares the output fairly among requesters (round-robin mode). It sits between several producer blocks and one consumer in the LU datapath.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SELW, max(1, clog2(CHANNELS)), derived select width; not overridden
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- mode  input  1  0 = fixed (channel sel), 1 = round-robin
- sel  input  SELW  channel chosen in fixed mode; ignored in round-robin; values ≥ CHANNELS grant nothing
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i offers a word
- in_ready  output  CHANNELS  channel i word accepted this cycle (combinational)
- out_data  output  WIDTH  registered word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- State: output register (out_data, out_sel, out_valid), round-robin pointer ptr (SELW bits).
- load = !out_valid || out_ready (register empty, or draining this cycle).
- Fixed mode: grant = one-hot(sel) & in_valid.
- Round-robin mode: grant = first i with in_valid[i] set, searching ptr, ptr+1, … CHANNELS-1, 0, … ptr-1 (wrap-around modulo CHANNELS).
- in_ready = grant & {CHANNELS{load}}; at most one bit set. No combinational path from in_valid[i] to in_ready[j] outside the grant logic; out_ready reaches in_ready combinationally (full-throughput pass).
- Transfer on channel i when in_valid[i] && in_ready[i]: next edge loads out_data ← word i, out_sel ← i, out_valid ← 1.
- load && no grant: out_valid ← 0 (if draining), out_data/out_sel hold.
- !load: register holds; producers must keep in_valid and data stable until accepted.
- ptr: on a round-robin transfer from channel i, ptr ← (i+1) mod CHANNELS; unchanged in fixed mode and when no transfer.
- mode or sel changes take effect the same cycle; a word already in the output register is unaffected.

## Timing
- Reset (asserted, any time): out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0 while reset is high. A word in flight is discarded.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle when out_ready held high.
- Back-pressure: out_valid && !out_ready → all in_ready=0; out_data stable.
- Simultaneous drain and fill: out_ready high with a granted requester → old word leaves and new word loads on the same edge, out_valid stays 1.
- Round-robin fairness: with all CHANNELS requesting continuously, each channel is granted exactly once every CHANNELS transfers.

## Structure
- Package rr_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 constants; clog2 helper function.
- Sub-module rr_pick: combinational rotating-priority picker (req, ptr → one-hot grant, index, any). rr_mux holds the register, pointer, and mode muxing.

## Test plan
- Reset mid-transfer: out_valid=1 with data 8'hA5, assert reset → out_valid=0, out_data=0, ptr=0 immediately; deassert → no spurious transfer.
- Fixed mode, sel=2, all in_valid=4'b1111, out_ready=1 → in_ready=4'b0100 every cycle; out_sel=2, out_data=channel 2 word, one cycle later.
- Round-robin, all four requesting, out_ready=1 → out_sel sequence 0,1,2,3,0,… ; in_ready one-hot rotating.
- Round-robin sparse: in_valid=4'b1001, ptr=1 → channel 3 granted, ptr←0; next grant channel 0 (wrap-around).
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles with requesters present → in_ready=0, out_data unchanged; out_ready=1 → new word loads same edge, out_valid stays 1.
- Fixed mode, sel=3, in_valid[3]=0 → no transfer, out_valid falls after drain, ptr unchanged; sel ≥ CHANNELS with CHANNELS=3 → no grant.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and width helpers for the round-robin mux
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Select fields are never narrower than one bit, even for a single channel.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker: first request at or after ptr wins
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - registered N-channel mux with valid/ready handshake, fixed or round-robin grant
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic                load;
  logic [CHANNELS-1:0] fix_grant, rr_grant, grant;
  logic [SELW-1:0]     rr_idx, widx;
  logic                rr_any, any_grant;
  logic [WIDTH-1:0]    word;

  rr_pick #(.N(CHANNELS), .PW(SELW)) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Out-of-range sel values match no channel, so they grant nothing.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SELW'(i)) fix_grant[i] = in_valid[i];
    end
  end

  assign load      = !out_valid_q || out_ready;
  assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign any_grant = |grant;
  assign in_ready  = reset ? '0 : (grant & {CHANNELS{load}});

  always_comb begin
    word = '0;
    widx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        word = in_data[i*WIDTH +: WIDTH];
        widx = SELW'(i);
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any_grant) begin
        out_valid_d = 1'b1;
        out_data_d  = word;
        out_sel_d   = widx;
        if (mode == MODE_RR) begin
          ptr_d = (widx == SELW'(CHANNELS - 1)) ? '0 : widx + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb/tb_rr_mux.sv - random and directed checks of rr_mux against a behavioural reference model
module tb_rr_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;

  int total = 0;
  int bad   = 0;

  logic       m_valid;
  logic [7:0] m_data;
  int         m_sel;
  int         m_ptr;

  always #5 clk = ~clk;

  rr_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner chosen from the arbitration rules: -1 means nobody is granted.
  function automatic int exp_pick(input logic m, input int s, input logic [3:0] v, input int p);
    if (!m) return (s < 4 && v[s]) ? s : -1;
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic step();
    int         g;
    logic       ld;
    logic [3:0] exp_rdy;
    @(negedge clk);
    ld = !m_valid || out_ready;
    g  = exp_pick(mode, int'(sel), in_valid, m_ptr);
    exp_rdy = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
    @(posedge clk);
    #1;
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*8 +: 8];
        m_sel   = g;
        if (mode) m_ptr = (g + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_data", {24'b0, out_data}, {24'b0, m_data});
    check("out_sel", {30'b0, out_sel}, m_sel);
  endtask

  initial begin
    logic [7:0] held;
    reset = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    in_data = 32'h44332211; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = 24'h0; out_ready3 = 1'b1;
    model_reset();
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_out_sel", {30'b0, out_sel}, 0);
    check("rst_in_ready", {28'b0, in_ready}, 0);
    in_valid = 4'h0;
    reset = 1'b0;

    // Fixed mode, channel 2 only
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'hD4C3B2A1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fix_sel2", {30'b0, out_sel}, 2);
    end

    // Round-robin fairness with everyone requesting
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      step();
      check("rr_order", {30'b0, out_sel}, i % 4);
    end

    // Sparse requests wrap around past the top channel
    in_valid = 4'b0001; step();
    in_valid = 4'b1001; step();
    check("rr_sparse3", {30'b0, out_sel}, 3);
    step();
    check("rr_wrap0", {30'b0, out_sel}, 0);

    // Back-pressure holds the register and blocks every producer
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; in_data = 32'h1E2D3C4B; step();
    held = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      step();
      check("bp_hold", {24'b0, out_data}, {24'b0, held});
    end
    out_ready = 1'b1; in_data = 32'h55667788; step();
    check("bp_refill_valid", {31'b0, out_valid}, 1);

    // Fixed select of an idle channel drains and leaves the pointer alone
    sel = 2'd3; in_valid = 4'b0111; step();
    check("fix_idle_drain", {31'b0, out_valid}, 0);
    mode = 1'b1; in_valid = 4'hF; step();
    check("ptr_kept", {30'b0, out_sel}, 1);

    // Asynchronous reset discards a word in flight
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h000000A5; step();
    check("pre_rst_word", {24'b0, out_data}, 32'hA5);
    in_valid = 4'hF; out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 0);
    check("mid_rst_data", {24'b0, out_data}, 0);
    check("mid_rst_ready", {28'b0, in_ready}, 0);
    in_valid = 4'h0;
    #1 reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    step();
    check("post_rst_idle", {31'b0, out_valid}, 0);
    mode = 1'b1; in_valid = 4'hF; step();
    check("post_rst_ptr0", {30'b0, out_sel}, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Three-channel instance: out-of-range select and wrap at CHANNELS
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'hCCBBAA; out_ready3 = 1'b1;
    @(negedge clk);
    check("c3_sel3_ready", {29'b0, in_ready3}, 0);
    @(posedge clk); #1;
    check("c3_sel3_valid", {31'b0, out_valid3}, 0);
    sel3 = 2'd2;
    @(negedge clk);
    check("c3_sel2_ready", {29'b0, in_ready3}, 32'h4);
    @(posedge clk); #1;
    check("c3_sel2_valid", {31'b0, out_valid3}, 1);
    check("c3_sel2_data", {24'b0, out_data3}, 32'hCC);
    check("c3_sel2_sel", {30'b0, out_sel3}, 2);
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("c3_rr_order", {30'b0, out_sel3}, k % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
